// File: rtl/lbp_pkg.sv
// Shared definitions for the LBP histogram block: code/bin sizing, drain FSM
// state encoding and the interior-pixel test used to filter border samples.
package lbp_pkg;

    localparam int IMG_LOG2_DEF = 7;
    localparam int CODE_W       = 8;
    localparam int NUM_BINS     = 256;

    typedef enum logic [1:0] {
        ST_ACCUM = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHOW  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    // True when the pixel is not on the outer one-pixel border of the frame.
    // Address layout is {row, col}, each log2 bits wide.
    function automatic logic is_interior(input logic [31:0] addr, input int unsigned log2);
        logic [31:0] mask;
        logic [31:0] row;
        logic [31:0] col;
        mask = (32'd1 << log2) - 32'd1;
        row  = (addr >> log2) & mask;
        col  = addr & mask;
        return (row >= 32'd1) && (row <= mask - 32'd1) &&
               (col >= 32'd1) && (col <= mask - 32'd1);
    endfunction

endpackage

// File: rtl/lbp_hist.sv
// 256-bin histogram of interior LBP codes for one frame. Accumulates while the
// engine runs, then drains every bin (or only non-zero bins) over valid/ready.
module lbp_hist
    import lbp_pkg::*;
#(
    parameter int IMG_LOG2  = IMG_LOG2_DEF,
    parameter int CNT_W     = 14,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  lbp_valid,
    input  logic [2*IMG_LOG2-1:0] lbp_addr,
    input  logic [CODE_W-1:0]     lbp_data,
    input  logic                  finish,
    output logic                  hist_valid,
    input  logic                  hist_ready,
    output logic [CODE_W-1:0]     hist_bin,
    output logic [CNT_W-1:0]      hist_count,
    output logic                  hist_done
);

    localparam logic [CODE_W-1:0] LAST_IDX = CODE_W'(NUM_BINS - 1);

    state_e              state_q, state_d;
    logic [CODE_W-1:0]   idx_q, idx_d;
    logic                hist_valid_q, hist_valid_d;
    logic [CODE_W-1:0]   hist_bin_q, hist_bin_d;
    logic [CNT_W-1:0]    hist_count_q, hist_count_d;
    logic                hist_done_q, hist_done_d;

    logic [CNT_W-1:0]    bins_q [NUM_BINS];
    logic                inc_en;
    logic [CNT_W-1:0]    cur_bin;

    // Only interior samples seen while accumulating are counted.
    assign inc_en  = (state_q == ST_ACCUM) && lbp_valid &&
                     is_interior(32'(lbp_addr), IMG_LOG2);
    assign cur_bin = bins_q[idx_q];

    // Each bin is its own saturating counter; a whole array of flops lets every
    // bin clear in one cycle and makes back-to-back hits on one bin trivially safe.
    generate
        for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_bin
            always_ff @(posedge clk) begin
                if (reset) begin
                    bins_q[gi] <= '0;
                end else if (inc_en && (lbp_data == CODE_W'(gi)) && (bins_q[gi] != '1)) begin
                    bins_q[gi] <= bins_q[gi] + CNT_W'(1);
                end
            end
        end
    endgenerate

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_ACCUM;
            idx_q        <= '0;
            hist_valid_q <= 1'b0;
            hist_bin_q   <= '0;
            hist_count_q <= '0;
            hist_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            hist_valid_q <= hist_valid_d;
            hist_bin_q   <= hist_bin_d;
            hist_count_q <= hist_count_d;
            hist_done_q  <= hist_done_d;
        end
    end

    // Next-state logic; valid/done are decoded from the next state so that the
    // registered outputs track the state register exactly.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        hist_bin_d   = hist_bin_q;
        hist_count_d = hist_count_q;
        unique case (state_q)
            ST_ACCUM: begin
                if (finish) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                hist_bin_d   = idx_q;
                hist_count_d = cur_bin;
                if (SKIP_ZERO && (cur_bin == '0)) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + CODE_W'(1);
                    end
                end else begin
                    state_d = ST_SHOW;
                end
            end
            ST_SHOW: begin
                if (hist_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d   = idx_q + CODE_W'(1);
                        state_d = ST_LOAD;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_DONE;
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
        hist_valid_d = (state_d == ST_SHOW);
        hist_done_d  = (state_d == ST_DONE);
    end

    assign hist_valid = hist_valid_q;
    assign hist_bin   = hist_bin_q;
    assign hist_count = hist_count_q;
    assign hist_done  = hist_done_q;

endmodule
